// File: rtl/mem_access_stage.sv
// mem_access_stage: accepts one execute-stage op, retires ALU results and issues loads/stores to memory_interface.
// Latency: ALU ops and faults answer 1 cycle after acceptance; memory ops finish 1 cycle after the completion strobe.
// Backpressure: ex_ready only in IDLE; busy holds the request in REQ; TIMEOUT_CYCLES bounds every wait.
// Optional build macro MEM_STAGE_ALIGN_CHECK_EN rejects misaligned halfword/word accesses with err_code 2'b10.
module mem_access_stage #(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic                  ex_load,
    input  logic                  ex_store,
    input  logic                  ex_signed,
    input  logic [1:0]            ex_word_type,
    input  logic [31:0]           ex_result,
    input  logic [31:0]           ex_wdata,
    input  logic [3:0]            ex_rd,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [31:0]           data_in,
    output logic                  load,
    output logic                  store,
    output logic                  is_signed,
    output logic [1:0]            word_type,
    input  logic [31:0]           data_out,
    input  logic                  output_valid,
    input  logic                  write_ready,
    input  logic                  busy,
    output logic                  wb_valid,
    output logic [3:0]            wb_rd,
    output logic [31:0]           wb_data,
    output logic                  st_done,
    output logic                  err,
    output logic [1:0]            err_code
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_LD = 2'd2,
        WAIT_ST = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] tmo_cnt;
    logic       op_is_load;
    logic [3:0] rd_q;

    logic accept;
    logic illegal;
    logic mem_kind;
    logic misalign;
    logic timeout;

    assign ex_ready = (state == IDLE) && !reset;
    assign accept   = ex_valid && ex_ready;
    assign illegal  = (ex_load && ex_store) || (ex_word_type == 2'b11);
    assign mem_kind = ex_load || ex_store;
    // Counter holds the number of cycles already spent in REQ/WAIT_*; the
    // last allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
    assign timeout  = (tmo_cnt == TMO_LAST);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign misalign = mem_kind &&
                      (((ex_word_type == 2'b10) && (ex_result[1:0] != 2'b00)) ||
                       ((ex_word_type == 2'b01) && ex_result[0]));
`else
    assign misalign = 1'b0;
`endif

    // Next-state and the single-cycle load/store request strobes.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        store     = 1'b0;
        case (state)
            IDLE: begin
                if (accept && mem_kind && !illegal && !misalign) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // A request that has run out of time is abandoned rather than issued.
                if (timeout) begin
                    state_nxt = IDLE;
                end else if (!busy) begin
                    load      = op_is_load;
                    store     = !op_is_load;
                    state_nxt = op_is_load ? WAIT_LD : WAIT_ST;
                end
            end
            WAIT_LD: begin
                if (output_valid || timeout) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_ST: begin
                if (write_ready || timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timeout counter: parked at zero in IDLE so it starts from zero on REQ entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= 8'd0;
        end else if (state == IDLE) begin
            tmo_cnt <= 8'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    // Capture the request on acceptance; held stable until the next memory op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address    <= '0;
            data_in    <= 32'd0;
            is_signed  <= 1'b0;
            word_type  <= 2'b00;
            rd_q       <= 4'd0;
            op_is_load <= 1'b0;
        end else if (accept && mem_kind && !illegal && !misalign) begin
            address    <= ex_result[ADDR_WIDTH-1:0];
            data_in    <= ex_wdata;
            is_signed  <= ex_signed;
            word_type  <= ex_word_type;
            rd_q       <= ex_rd;
            op_is_load <= ex_load;
        end
    end

    // Result pulses; completion is tested before timeout so it wins a tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_rd    <= 4'd0;
            wb_data  <= 32'd0;
            st_done  <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            wb_valid <= 1'b0;
            st_done  <= 1'b0;
            err      <= 1'b0;
            if (accept) begin
                if (illegal) begin
                    err      <= 1'b1;
                    err_code <= 2'b01;
                end else if (misalign) begin
                    err      <= 1'b1;
                    err_code <= 2'b10;
                end else if (!mem_kind) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= ex_rd;
                    wb_data  <= ex_result;
                end
            end else if ((state == WAIT_LD) && output_valid) begin
                // Extension is done by memory_interface; forward as-is.
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                wb_data  <= data_out;
            end else if ((state == WAIT_ST) && write_ready) begin
                st_done <= 1'b1;
            end else if ((state != IDLE) && timeout) begin
                err      <= 1'b1;
                err_code <= 2'b11;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scenarios plus randomized traffic against a transaction-level reference model.
// A responder process plays memory_interface (byte-array image, random busy/latency, lost and spurious strobes).
// Inputs change 1-2 time units after the rising edge; all outputs are sampled on the falling edge.
module tb_mem_access_stage;

    localparam int AW = 12;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_valid, ex_ready, ex_load, ex_store, ex_signed;
    logic [1:0]    ex_word_type;
    logic [31:0]   ex_result, ex_wdata;
    logic [3:0]    ex_rd;
    logic [AW-1:0] address;
    logic [31:0]   data_in;
    logic          load, store, is_signed;
    logic [1:0]    word_type;
    logic [31:0]   data_out;
    logic          output_valid, write_ready, busy;
    logic          wb_valid;
    logic [3:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          st_done, err;
    logic [1:0]    err_code;

    int checks   = 0;
    int failures = 0;

    mem_access_stage #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load), .ex_store(ex_store),
        .ex_signed(ex_signed), .ex_word_type(ex_word_type), .ex_result(ex_result),
        .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .address(address), .data_in(data_in), .load(load), .store(store),
        .is_signed(is_signed), .word_type(word_type),
        .data_out(data_out), .output_valid(output_valid), .write_ready(write_ready), .busy(busy),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .st_done(st_done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // ---------------- memory_interface stand-in ----------------
    logic [7:0] mem [0:4095];

    function automatic logic [31:0] mem_read(input logic [11:0] a, input logic [1:0] wt, input logic sg);
        logic [7:0]  b;
        logic [15:0] h;
        case (wt)
            2'b00: begin
                b = mem[a];
                return sg ? {{24{b[7]}}, b} : {24'd0, b};
            end
            2'b01: begin
                h = {mem[a + 12'd1], mem[a]};
                return sg ? {{16{h[15]}}, h} : {16'd0, h};
            end
            default: return {mem[a + 12'd3], mem[a + 12'd2], mem[a + 12'd1], mem[a]};
        endcase
    endfunction

    int          rsp_busy_pct = 0;
    int          rsp_lat      = 1;   // -1 picks 0..3 at random
    int          never_pct    = 0;   // chance a request is never answered
    bit          rsp_spur     = 1'b0;
    int          busy_until   = 0;
    int          force_req    = 0;
    int          force_seen   = 0;
    int          req_seq      = 0;
    int          seen_seq     = 0;
    logic [11:0] r_addr;
    logic [1:0]  r_wt;
    logic        r_sg, r_ld;
    logic [31:0] r_wd;
    bit          r_act = 1'b0;
    int          r_cd  = 0;

    // Capture issued requests on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!reset && (load || store)) begin
            r_addr = address;
            r_wt   = word_type;
            r_sg   = is_signed;
            r_wd   = data_in;
            r_ld   = load;
            req_seq++;
        end
    end

    // Drive memory-side inputs shortly after each rising edge.
    initial begin
        busy = 1'b0; output_valid = 1'b0; write_ready = 1'b0; data_out = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            output_valid = 1'b0;
            write_ready  = 1'b0;
            data_out     = $urandom;
            busy = (cyc < busy_until) || ($urandom_range(99) < rsp_busy_pct);
            if (reset) begin
                r_act    = 1'b0;
                seen_seq = req_seq;
            end else if (req_seq != seen_seq) begin
                seen_seq = req_seq;
                r_act    = ($urandom_range(99) >= never_pct);
                r_cd     = (rsp_lat >= 0) ? rsp_lat : int'($urandom_range(3));
            end
            if (force_req != force_seen) begin
                force_seen   = force_req;
                output_valid = 1'b1;
            end else if (r_act) begin
                if (r_cd == 0) begin
                    r_act = 1'b0;
                    if (r_ld) begin
                        output_valid = 1'b1;
                        data_out     = mem_read(r_addr, r_wt, r_sg);
                    end else begin
                        write_ready = 1'b1;
                        mem[r_addr] = r_wd[7:0];
                        if (r_wt != 2'b00) mem[r_addr + 12'd1] = r_wd[15:8];
                        if (r_wt == 2'b10) begin
                            mem[r_addr + 12'd2] = r_wd[23:16];
                            mem[r_addr + 12'd3] = r_wd[31:24];
                        end
                    end
                end else begin
                    r_cd--;
                end
            end else if (rsp_spur && ($urandom_range(15) == 0)) begin
                if ($urandom_range(1) == 1) output_valid = 1'b1;
                else                        write_ready  = 1'b1;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    // One outstanding memory op at most: "elapsed" counts cycles since the
    // op was accepted into the request phase, "issued" says whether the
    // memory has seen it yet. Pulses computed now are due next cycle.
    logic        m_pend = 1'b0, m_ld, m_sg, m_issued;
    logic [11:0] m_addr;
    logic [31:0] m_wd;
    logic [1:0]  m_wt;
    logic [3:0]  m_rd;
    int          m_elapsed;
    logic        e_wb = 1'b0, e_st = 1'b0, e_err = 1'b0;
    logic [3:0]  e_rd = 4'd0;
    logic [31:0] e_data = 32'd0;
    logic [1:0]  e_code = 2'b00;
    int          n_wb = 0, n_st = 0, n_err = 0;

    initial forever begin
        logic tmo_now, x_ld, x_st, bad, mis;
        @(negedge clk);
        if (reset) begin
            chk("reset_outputs_zero", 32'(|{ex_ready, address, data_in, load, store, is_signed,
                word_type, wb_valid, wb_rd, wb_data, st_done, err, err_code}), 32'd0);
            m_pend = 1'b0; e_wb = 1'b0; e_st = 1'b0; e_err = 1'b0; e_code = 2'b00;
        end else begin
            tmo_now = m_pend && (m_elapsed == T - 1);
            x_ld    = m_pend && !m_issued && m_ld  && !busy && !tmo_now;
            x_st    = m_pend && !m_issued && !m_ld && !busy && !tmo_now;
            chk("ex_ready", 32'(ex_ready), 32'(!m_pend));
            chk("load", 32'(load), 32'(x_ld));
            chk("store", 32'(store), 32'(x_st));
            chk("wb_valid", 32'(wb_valid), 32'(e_wb));
            chk("st_done", 32'(st_done), 32'(e_st));
            chk("err", 32'(err), 32'(e_err));
            chk("err_code", 32'(err_code), 32'(e_code));
            chk("pulse_exclusive", 32'({wb_valid, st_done, err} inside {3'b000, 3'b001, 3'b010, 3'b100}), 32'd1);
            if (e_wb) begin
                chk("wb_rd", 32'(wb_rd), 32'(e_rd));
                chk("wb_data", wb_data, e_data);
            end
            if (x_ld || x_st) begin
                chk("req_address", 32'(address), 32'(m_addr));
                chk("req_data_in", data_in, m_wd);
                chk("req_word_type", 32'(word_type), 32'(m_wt));
                chk("req_is_signed", 32'(is_signed), 32'(m_sg));
            end
            if (wb_valid) n_wb++;
            if (st_done)  n_st++;
            if (err)      n_err++;

            e_wb = 1'b0; e_st = 1'b0; e_err = 1'b0;
            if (!m_pend) begin
                if (ex_valid) begin
                    bad = (ex_load && ex_store) || (ex_word_type == 2'b11);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
                    mis = (ex_load || ex_store) &&
                          ((ex_word_type == 2'b10 && ex_result[1:0] != 2'b00) ||
                           (ex_word_type == 2'b01 && ex_result[0]));
`else
                    mis = 1'b0;
`endif
                    if (bad) begin
                        e_err = 1'b1; e_code = 2'b01;
                    end else if (mis) begin
                        e_err = 1'b1; e_code = 2'b10;
                    end else if (ex_load || ex_store) begin
                        m_pend = 1'b1; m_ld = ex_load; m_sg = ex_signed; m_wt = ex_word_type;
                        m_addr = ex_result[11:0]; m_wd = ex_wdata; m_rd = ex_rd;
                        m_issued = 1'b0; m_elapsed = 0;
                    end else begin
                        e_wb = 1'b1; e_rd = ex_rd; e_data = ex_result;
                    end
                end
            end else if (m_issued && (m_ld ? output_valid : write_ready)) begin
                if (m_ld) begin
                    e_wb = 1'b1; e_rd = m_rd; e_data = data_out;
                end else begin
                    e_st = 1'b1;
                end
                m_pend = 1'b0;
            end else if (tmo_now) begin
                e_err = 1'b1; e_code = 2'b11; m_pend = 1'b0;
            end else begin
                m_elapsed++;
                if (!m_issued && !busy) m_issued = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic ld, input logic st, input logic sg, input logic [1:0] wt,
                         input logic [31:0] res, input logic [31:0] wd, input logic [3:0] rd);
        int n = 0;
        while (!ex_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("issue_ready_wait", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_signed = sg;
        ex_word_type = wt; ex_result = res; ex_wdata = wd; ex_rd = rd;
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a, b, c;
        bit done;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        reset = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_signed = 1'b0;
        ex_word_type = 2'b00; ex_result = 32'd0; ex_wdata = 32'd0; ex_rd = 4'd0;
        @(negedge clk);
        chk("reset_ex_ready", 32'(ex_ready), 32'd0);
        chk("reset_err_code", 32'(err_code), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // ALU op
        @(posedge clk); #1;
        issue(1'b0, 1'b0, 1'b0, 2'b10, 32'h12345678, 32'd0, 4'd3);
        @(negedge clk);
        chk("alu_wb_valid", 32'(wb_valid), 32'd1);
        chk("alu_wb_rd", 32'(wb_rd), 32'd3);
        chk("alu_wb_data", wb_data, 32'h12345678);
        chk("alu_ex_ready", 32'(ex_ready), 32'd1);

        // Store halfword, memory answers after 2 wait cycles
        rsp_lat = 2;
        @(posedge clk); #1;
        issue(1'b0, 1'b1, 1'b0, 2'b01, 32'h00000eee, 32'hdeadbeef, 4'd7);
        @(negedge clk);
        chk("st_store", 32'(store), 32'd1);
        chk("st_address", 32'(address), 32'h00000eee);
        chk("st_data_in", data_in, 32'hdeadbeef);
        chk("st_word_type", 32'(word_type), 32'd1);
        chk("st_ex_ready", 32'(ex_ready), 32'd0);
        done = 1'b0; a = 0; b = 0; c = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (st_done) done = 1'b1;
            else if (ex_ready) a++;
            if (store)    b++;
            if (wb_valid) c++;
        end
        chk("st_done_seen", 32'(done), 32'd1);
        chk("st_ready_early", 32'(a), 32'd0);
        chk("st_extra_store", 32'(b), 32'd0);
        chk("st_no_wb", 32'(c), 32'd0);

        // Signed halfword load back, busy for 3 cycles
        rsp_lat = 1;
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 1'b1, 2'b01, 32'h00000eee, 32'd0, 4'd5);
        busy_until = cyc + 3;
        n = 0;
        @(negedge clk);
        while (!load && n < 20) begin
            n++; @(negedge clk);
        end
        chk("ld_busy_delay", 32'(n), 32'd3);
        n = 0;
        while (!wb_valid && n < 20) begin
            n++; @(negedge clk);
        end
        chk("ld_wb_valid", 32'(wb_valid), 32'd1);
        chk("ld_wb_rd", 32'(wb_rd), 32'd5);
        chk("ld_wb_data", wb_data, 32'hffffbeef);

        // Misaligned word load
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h00000eed, 32'd0, 4'd2);
        @(negedge clk);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        chk("mis_err", 32'(err), 32'd1);
        chk("mis_err_code", 32'(err_code), 32'd2);
        chk("mis_ex_ready", 32'(ex_ready), 32'd1);
        b = 0;
        for (int i = 0; i < 5; i++) begin
            if (load) b++;
            @(negedge clk);
        end
        chk("mis_no_load", 32'(b), 32'd0);
`else
        chk("mis_load", 32'(load), 32'd1);
        chk("mis_address", 32'(address), 32'h00000eed);
        n = 0;
        while (!wb_valid && n < 20) begin
            n++; @(negedge clk);
        end
        chk("mis_wb_valid", 32'(wb_valid), 32'd1);
`endif

        // Memory never answers: timeout T cycles after REQ entry
        never_pct = 100;
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h00000100, 32'd0, 4'd4);
        n = 0;
        @(negedge clk);
        while (!err && n < 40) begin
            n++; @(negedge clk);
        end
        chk("tmo_delay", 32'(n), 32'd8);
        chk("tmo_err_code", 32'(err_code), 32'd3);
        chk("tmo_no_wb", 32'(wb_valid), 32'd0);
        @(negedge clk);
        chk("tmo_ex_ready_after", 32'(ex_ready), 32'd1);

        // Reset in WAIT_LD, then a late output_valid
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 1'b0, 2'b10, 32'h00000200, 32'd0, 4'd6);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_zero", 32'(|{ex_ready, address, data_in, load, store, is_signed,
            word_type, wb_valid, wb_rd, wb_data, st_done, err, err_code}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        never_pct = 0;
        force_req++;
        a = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wb_valid || st_done || err) a++;
        end
        chk("rst_no_late_result", 32'(a), 32'd0);
        chk("rst_idle_ready", 32'(ex_ready), 32'd1);

        // Randomized traffic
        rsp_busy_pct = 30; rsp_lat = -1; never_pct = 8; rsp_spur = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            int k;
            @(posedge clk); #1;
            if (i == 700) reset = 1'b1;
            if (i == 702) reset = 1'b0;
            k = int'($urandom_range(99));
            ex_valid = reset ? 1'b0 : ($urandom_range(2) != 0);
            ex_word_type = 2'($urandom_range(2));
            ex_load = 1'b0; ex_store = 1'b0;
            if (k < 40)      ex_load = 1'b1;
            else if (k < 70) ex_store = 1'b1;
            else if (k < 90) ex_load = 1'b0;
            else if (k < 95) begin ex_load = 1'b1; ex_store = 1'b1; end
            else begin ex_load = 1'b1; ex_word_type = 2'b11; end
            ex_signed = 1'($urandom);
            ex_result = $urandom;
            if (k % 2 == 0) ex_result[1:0] = 2'b00;
            ex_wdata = $urandom;
            ex_rd = 4'($urandom);
        end
        ex_valid = 1'b0;
        rsp_spur = 1'b0;
        repeat (30) @(posedge clk);
        chk("rand_wb_activity", 32'(n_wb > 50), 32'd1);
        chk("rand_st_activity", 32'(n_st > 20), 32'd1);
        chk("rand_err_activity", 32'(n_err > 10), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
